// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared header field positions, limits and enums for the
//               router packet receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int MAX_LEN  = 63;

    typedef enum logic [1:0] {
        ERR_PARITY   = 2'd0,
        ERR_ADDR     = 2'd1,
        ERR_ZERO_LEN = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/router_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_buf
// Description : 64 x 8 payload buffer, single write port, read by an index
//               held in a register by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_buf
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [5:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    logic [7:0] r_mem [0:MAX_LEN];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/router_pkt_receiver.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_receiver
// Description : Drains one router output port, validates each packet and
//               streams good payloads to a valid/ready client.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_receiver
    import router_pkg::*;
#(
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         WARN_WAIT  = 24,
    parameter int         RD_TIMEOUT = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vld_in,
    input  logic [7:0]  data_in,
    output logic        read_enb,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        stall_warn,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    rx_state_e  r_state, w_next;
    logic       r_rd_q;
    logic [6:0] r_issued, r_cap;
    logic [5:0] r_len, r_rd_ptr;
    logic [1:0] r_addr;
    logic [7:0] r_xor;
    logic [15:0] r_idle, r_wait, r_pkt_cnt, r_err_cnt;
    logic       r_stall;

    logic [6:0] w_limit, w_cap_m1;
    logic       w_timeout, w_par_cap, w_ok, w_accept, w_last, w_wr_en, w_wait_inc;
    err_code_e  w_code;
    logic [7:0] w_buf_data;

    // Before the header is seen, two blind reads are always safe (len >= 0).
    always_comb begin
        w_limit = 7'd2;
        if (r_cap != 7'd0) begin
            w_limit = {1'b0, r_len} + 7'd2;
        end else if (r_rd_q) begin
            w_limit = {1'b0, data_in[LEN_MSB:LEN_LSB]} + 7'd2;
        end
    end

    assign w_timeout = (r_state == ST_READ) && !r_rd_q && (r_idle == 16'(RD_TIMEOUT - 1));
    assign w_par_cap = r_rd_q && (r_cap != 7'd0) && (r_cap == {1'b0, r_len} + 7'd1);
    assign w_accept  = (r_state == ST_DRAIN) && out_ready;
    assign w_last    = (r_rd_ptr == r_len - 6'd1);
    assign w_cap_m1  = r_cap - 7'd1;
    assign w_wr_en   = (r_state == ST_READ) && r_rd_q && (r_cap != 7'd0) && (r_cap <= {1'b0, r_len});
    assign w_wait_inc = ((r_state == ST_CHECK) || (r_state == ST_DRAIN)) && vld_in;

    always_comb begin
        w_ok   = 1'b0;
        w_code = ERR_PARITY;
        if (r_addr != PORT_ID) begin
            w_code = ERR_ADDR;
        end else if (r_len == 6'd0) begin
            w_code = ERR_ZERO_LEN;
        end else if (r_xor != 8'h00) begin
            w_code = ERR_PARITY;
        end else begin
            w_ok = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (vld_in) w_next = ST_READ;
            ST_READ: begin
                if (w_timeout) begin
                    w_next = ST_IDLE;
                end else if (w_par_cap) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: w_next = w_ok ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (w_accept && w_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        read_enb  = (r_state == ST_READ) && vld_in && (r_issued < w_limit) && !w_timeout;
        out_valid = (r_state == ST_DRAIN);
        out_last  = (r_state == ST_DRAIN) && w_last;
        out_data  = (r_state == ST_DRAIN) ? w_buf_data : 8'h00;
        pkt_ok    = (r_state == ST_CHECK) && w_ok;
        pkt_err   = ((r_state == ST_CHECK) && !w_ok) || w_timeout;
        err_code  = 2'd0;
        if (r_state == ST_CHECK && !w_ok) begin
            err_code = w_code;
        end else if (w_timeout) begin
            err_code = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_q    <= 1'b0;
            r_issued  <= 7'd0;
            r_cap     <= 7'd0;
            r_len     <= 6'd0;
            r_addr    <= 2'd0;
            r_xor     <= 8'h00;
            r_idle    <= 16'd0;
            r_rd_ptr  <= 6'd0;
        end else begin
            r_rd_q <= read_enb;
            case (r_state)
                ST_IDLE: begin
                    r_issued <= 7'd0;
                    r_cap    <= 7'd0;
                    r_xor    <= 8'h00;
                    r_idle   <= 16'd0;
                    r_rd_ptr <= 6'd0;
                end
                ST_READ: begin
                    if (read_enb) r_issued <= r_issued + 7'd1;
                    if (r_rd_q) begin
                        r_cap  <= r_cap + 7'd1;
                        r_xor  <= r_xor ^ data_in;
                        r_idle <= 16'd0;
                        if (r_cap == 7'd0) begin
                            r_len  <= data_in[LEN_MSB:LEN_LSB];
                            r_addr <= data_in[ADDR_MSB:0];
                        end
                    end else begin
                        r_idle <= r_idle + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) r_rd_ptr <= w_last ? 6'd0 : r_rd_ptr + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Wait counter only runs while the port is not being serviced.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait    <= 16'd0;
            r_stall   <= 1'b0;
            r_pkt_cnt <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            r_stall <= w_wait_inc && (r_wait == 16'(WARN_WAIT - 1));
            if ((r_state == ST_CHECK) || (r_state == ST_DRAIN)) begin
                if (w_wait_inc && r_wait != 16'hFFFF) r_wait <= r_wait + 16'd1;
            end else begin
                r_wait <= 16'd0;
            end
            if (pkt_ok && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (pkt_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign stall_warn = r_stall;
    assign pkt_cnt    = r_pkt_cnt;
    assign err_cnt    = r_err_cnt;

    router_pkt_buf u_buf (
        .clk       (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_cap_m1[5:0]),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_buf_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_receiver
// Description : Directed bench with a small router-FIFO model feeding the
//               receiver; expected values are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_receiver;

    logic        clock = 1'b0;
    logic        reset, vld_in, read_enb, out_valid, out_last, out_ready;
    logic        pkt_ok, pkt_err, stall_warn;
    logic [7:0]  data_in, out_data;
    logic [1:0]  err_code;
    logic [15:0] pkt_cnt, err_cnt;

    always #5 clock = ~clock;

    router_pkt_receiver #(
        .PORT_ID    (2'd1),
        .WARN_WAIT  (24),
        .RD_TIMEOUT (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_in     (vld_in),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .stall_warn (stall_warn),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] rx[$];
    logic       rxl[$];
    logic       pend, hold, rdy, prev_stalled;
    logic [7:0] pend_b, prev_data;
    logic [1:0] last_code;
    int cyc_n, n_reads, n_ok, n_err, n_valid, n_stall, stall_cyc, hold_viol, t0, snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the FIFO model at the falling edge, then observe.
    task automatic cyc();
        @(negedge clock);
        cyc_n++;
        if (pend) data_in = pend_b;
        vld_in    = (q.size() != 0) && !hold;
        out_ready = rdy;
        #1;
        pend = read_enb;
        if (read_enb) begin
            n_reads++;
            pend_b = (q.size() != 0) ? q.pop_front() : 8'hEE;
        end
        if (out_valid) n_valid++;
        if (out_valid && out_ready) begin
            rx.push_back(out_data);
            rxl.push_back(out_last);
        end
        if (prev_stalled && out_data !== prev_data) hold_viol++;
        prev_stalled = out_valid && !out_ready;
        prev_data    = out_data;
        if (pkt_ok) n_ok++;
        if (pkt_err) begin
            n_err++;
            last_code = err_code;
        end
        if (stall_warn) begin
            n_stall++;
            stall_cyc = cyc_n;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr();
        rx.delete();
        rxl.delete();
        n_reads = 0; n_ok = 0; n_err = 0; n_valid = 0; n_stall = 0;
        stall_cyc = 0; hold_viol = 0; last_code = 2'd0;
    endtask

    // Header, len payload bytes (start, start+step, ...), then XOR parity.
    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] start,
                            input logic [7:0] step, input logic bad);
        logic [7:0] p, b;
        int len;
        p   = hdr;
        b   = start;
        len = int'(hdr[7:2]);
        q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            q.push_back(b);
            p ^= b;
            b += step;
        end
        if (bad) p ^= 8'h01;
        q.push_back(p);
    endtask

    initial begin
        reset = 1'b1; vld_in = 1'b0; data_in = 8'h00; out_ready = 1'b0;
        rdy = 1'b1; hold = 1'b0; pend = 1'b0; prev_stalled = 1'b0; prev_data = 8'h00;
        pend_b = 8'h00; cyc_n = 0; t0 = 0; snap = 0;
        clr();
        run(3);
        chk("rst_read_enb",  read_enb, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_pulses",    {pkt_ok, pkt_err, stall_warn}, 0);
        chk("rst_cnts",      {pkt_cnt, err_cnt}, 0);
        reset = 1'b0;

        // Good packet: 0D 11 22 33, parity 0D.
        clr();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        run(20);
        chk("good_reads", n_reads, 5);
        chk("good_len",   rx.size(), 3);
        chk("good_b0",    rx[0], 8'h11);
        chk("good_b1",    rx[1], 8'h22);
        chk("good_b2",    rx[2], 8'h33);
        chk("good_last",  {rxl[0], rxl[1], rxl[2]}, 3'b001);
        chk("good_ok",    n_ok, 1);
        chk("good_noerr", n_err, 0);
        chk("good_cnt",   pkt_cnt, 1);

        // Corrupted parity.
        clr();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b1);
        run(20);
        chk("par_reads", n_reads, 5);
        chk("par_valid", n_valid, 0);
        chk("par_err",   n_err, 1);
        chk("par_code",  last_code, 0);
        chk("par_cnt",   err_cnt, 1);
        chk("par_pcnt",  pkt_cnt, 1);

        // Address 2 on port 1.
        clr();
        push_pkt(8'h0E, 8'h11, 8'h11, 1'b0);
        run(20);
        chk("addr_reads", n_reads, 5);
        chk("addr_code",  last_code, 1);
        chk("addr_cnt",   err_cnt, 2);

        // Zero length: header 01, parity 01.
        clr();
        push_pkt(8'h01, 8'h00, 8'h00, 1'b0);
        run(12);
        chk("zlen_reads", n_reads, 2);
        chk("zlen_code",  last_code, 2);
        chk("zlen_cnt",   err_cnt, 3);

        // 5-cycle vld_in gap mid-payload: 11 A1 B2 C3 D4, parity 15.
        clr();
        push_pkt(8'h11, 8'hA1, 8'h11, 1'b0);
        run(4);
        hold = 1'b1;
        cyc();
        snap = n_reads;
        run(4);
        chk("gap_noread", n_reads, snap);
        hold = 1'b0;
        run(25);
        chk("gap_reads", n_reads, 6);
        chk("gap_len",   rx.size(), 4);
        chk("gap_b0",    rx[0], 8'hA1);
        chk("gap_b3",    rx[3], 8'hD4);
        chk("gap_ok",    n_ok, 1);
        chk("gap_cnt",   pkt_cnt, 2);

        // Timeout: vld_in held low well beyond 32 cycles.
        clr();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        run(4);
        hold = 1'b1;
        run(40);
        chk("to_err",   n_err, 1);
        chk("to_code",  last_code, 3);
        chk("to_cnt",   err_cnt, 4);
        chk("to_noack", n_ok, 0);
        q.delete();
        pend = 1'b0;
        hold = 1'b0;
        run(3);
        chk("to_idle", {read_enb, out_valid}, 2'b00);

        // Max-length packet, client stalled while the next packet waits.
        clr();
        rdy = 1'b0;
        push_pkt(8'hFD, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 200 && !out_valid; i++) cyc();
        chk("max_drain_reached", out_valid, 1);
        chk("max_reads", n_reads, 65);
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        t0 = cyc_n + 1;
        run(30);
        chk("stall_once",  n_stall, 1);
        chk("stall_delay", stall_cyc - t0, 24);
        chk("stall_hold",  hold_viol, 0);
        chk("stall_data",  out_data, 8'h01);
        rdy = 1'b1;
        run(100);
        chk("max_len", rx.size(), 66);
        for (int i = 0; i < 63; i++) chk("max_byte", rx[i], 8'(i + 1));
        chk("max_last", {rxl[61], rxl[62]}, 2'b01);
        chk("b2b_b0",   rx[63], 8'h11);
        chk("b2b_b2",   rx[65], 8'h33);
        chk("max_ok",   n_ok, 2);
        chk("max_cnt",  pkt_cnt, 4);
        chk("stall_still_once", n_stall, 1);

        // Asynchronous reset mid-READ.
        clr();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        run(3);
        chk("mid_reading", read_enb, 1);
        reset = 1'b1;
        #1;
        chk("arst_read_enb",  read_enb, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_cnts",      {pkt_cnt, err_cnt}, 0);
        q.delete();
        pend = 1'b0;
        run(2);
        reset = 1'b0;
        clr();
        push_pkt(8'h0D, 8'h11, 8'h11, 1'b0);
        run(20);
        chk("post_reads", n_reads, 5);
        chk("post_len",   rx.size(), 3);
        chk("post_b1",    rx[1], 8'h22);
        chk("post_cnt",   pkt_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
